// File: rtl/dsp_config_loader.sv
// Serialises parallel configuration words LSB-first into a DSP configuration chain,
// grouping words into frames that end with a one-cycle done pulse.
module dsp_config_loader #(
  parameter int CFG_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CFG_WIDTH-1:0] cfg_word,
  input  logic                 cfg_valid,
  input  logic                 cfg_last,
  output logic                 cfg_ready,
  input  logic                 cfg_abort,
  output logic                 configuration_input,
  output logic                 configuration_enable,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frame_words
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

  state_t               state;
  logic [CFG_WIDTH-1:0] shreg;
  logic                 last_q;
  logic [BW-1:0]        bit_cnt;
  logic                 final_bit;
  logic                 accept;

  assign final_bit = (state == SHIFT) && (bit_cnt == BW'(CFG_WIDTH - 1));
  // NOTE: cfg_ready is the only combinational output; it depends on state and abort, never on cfg_valid.
  assign cfg_ready = !cfg_abort && ((state == IDLE) || (final_bit && !last_q));
  assign accept    = cfg_valid && cfg_ready;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      shreg                <= '0;
      last_q               <= 1'b0;
      bit_cnt              <= '0;
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      frame_words          <= '0;
    end else if (cfg_abort) begin
      state                <= IDLE;
      bit_cnt              <= '0;
      configuration_input  <= 1'b0;
      configuration_enable <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      frame_words          <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Bit 0 goes out immediately; the remaining bits wait in shreg.
        state                <= SHIFT;
        shreg                <= cfg_word >> 1;
        last_q               <= cfg_last;
        bit_cnt              <= '0;
        configuration_input  <= cfg_word[0];
        configuration_enable <= 1'b1;
        busy                 <= 1'b1;
        if (frame_words != {CNT_WIDTH{1'b1}})
          frame_words <= frame_words + CNT_WIDTH'(1);
      end else begin
        unique case (state)
          SHIFT: begin
            if (final_bit) begin
              configuration_input  <= 1'b0;
              configuration_enable <= 1'b0;
              if (last_q) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt             <= bit_cnt + BW'(1);
              configuration_input <= shreg[0];
              shreg               <= shreg >> 1;
            end
          end
          DONE: begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_words <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_config_loader.sv
// Scoreboard bench: stimulus queues expected serial bits and done-time word counts,
// a negedge monitor pops and compares whenever the DUT shifts or pulses done.
module tb_dsp_config_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cfg_word;
  logic         cfg_valid;
  logic         cfg_last;
  logic         cfg_ready;
  logic         cfg_abort;
  logic         configuration_input;
  logic         configuration_enable;
  logic         busy;
  logic         done;
  logic [7:0]   frame_words;

  int checks = 0;
  int errors = 0;

  bit       exp_bits[$];
  int       exp_done[$];
  int       done_cnt = 0;
  int       cur_run  = 0;
  int       last_run = 0;
  int       fw_model = 0;

  dsp_config_loader #(.CFG_WIDTH(W), .CNT_WIDTH(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_word             (cfg_word),
    .cfg_valid            (cfg_valid),
    .cfg_last             (cfg_last),
    .cfg_ready            (cfg_ready),
    .cfg_abort            (cfg_abort),
    .configuration_input  (configuration_input),
    .configuration_enable (configuration_enable),
    .busy                 (busy),
    .done                 (done),
    .frame_words          (frame_words)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every enabled bit and every done pulse against the queues.
  always @(negedge clk) begin
    if (rst) begin
      cur_run = 0;
    end else begin
      if (!configuration_enable)
        check("input_zero_when_disabled", configuration_input, 1'b0);
      if (configuration_enable) begin
        cur_run++;
        check("busy_while_shifting", busy, 1'b1);
        if (exp_bits.size() == 0) check("unexpected_enable", 1'b1, 1'b0);
        else check("serial_bit", configuration_input, exp_bits.pop_front());
      end else if (cur_run > 0) begin
        last_run = cur_run;
        cur_run  = 0;
      end
      if (done) begin
        done_cnt++;
        check("done_enable_low", configuration_enable, 1'b0);
        if (exp_done.size() == 0) check("unexpected_done", 1'b1, 1'b0);
        else check("done_frame_words", frame_words, exp_done.pop_front());
      end
    end
  end

  // Present a word and hold it until accepted; queue nbits expected serial bits.
  task automatic send_word(input logic [W-1:0] word, input logic last, input int nbits);
    bit acc;
    int k = 0;
    cfg_word  = word;
    cfg_last  = last;
    cfg_valid = 1'b1;
    do begin
      acc = cfg_ready;
      @(posedge clk); #1;
      k++;
    end while (!acc && k < 100);
    if (!acc) begin
      check("accept_timeout", 1'b0, 1'b1);
      return;
    end
    for (int i = 0; i < nbits; i++) exp_bits.push_back(word[i]);
    fw_model = (fw_model == 255) ? 255 : fw_model + 1;
    check("frame_words_on_accept", frame_words, fw_model);
    if (last && nbits == W) begin
      exp_done.push_back(fw_model);
      fw_model = 0;
    end
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_count", done_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_word = '0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_abort = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_enable", configuration_enable, 1'b0);
    check("rst_input", configuration_input, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_frame_words", frame_words, 8'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("ready_after_rst", cfg_ready, 1'b1);
    @(posedge clk); #1;

    // Single word, one-word frame.
    send_word(8'hA5, 1'b1, W);
    cfg_valid = 1'b0;
    check("busy_in_shift", busy, 1'b1);
    wait_done(1);
    check("single_run_len", last_run, 8);
    check("fw_cleared_after_done", frame_words, 8'd0);
    check("idle_busy_low", busy, 1'b0);

    // Back-to-back words with valid held.
    send_word(8'h0F, 1'b0, W);
    send_word(8'hF0, 1'b1, W);
    cfg_valid = 1'b0;
    wait_done(2);
    check("b2b_run_len", last_run, 16);

    // Frame left open across a 5-cycle idle gap.
    send_word(8'h3C, 1'b0, W);
    cfg_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_enable", configuration_enable, 1'b0);
      check("gap_busy", busy, 1'b0);
      check("gap_frame_words_held", frame_words, 8'd1);
      if (i < 4) begin @(posedge clk); #1; end
    end
    check("gap_prev_run_len", last_run, 8);
    send_word(8'hC3, 1'b1, W);
    cfg_valid = 1'b0;
    wait_done(3);
    check("gap_second_run_len", last_run, 8);

    // Abort during the 4th bit cycle.
    send_word(8'hFF, 1'b1, 4);
    cfg_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    cfg_abort = 1'b1;
    @(negedge clk);
    check("ready_low_on_abort", cfg_ready, 1'b0);
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    fw_model = 0;
    check("abort_enable", configuration_enable, 1'b0);
    check("abort_frame_words", frame_words, 8'd0);
    check("abort_busy", busy, 1'b0);
    repeat (12) begin @(posedge clk); #1; end
    check("abort_run_len", last_run, 4);
    check("abort_no_done", done_cnt, 3);

    // Asynchronous reset in mid-shift.
    send_word(8'hA5, 1'b1, 2);
    cfg_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_enable", configuration_enable, 1'b0);
    check("async_rst_input", configuration_input, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_frame_words", frame_words, 8'd0);
    fw_model = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("ready_after_async_rst", cfg_ready, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    check("rst_no_done", done_cnt, 3);
    check("rst_queue_drained", exp_bits.size(), 0);

    // Long frame: counter saturates.
    for (int i = 0; i < 300; i++) send_word(i[7:0], 1'b0, W);
    send_word(8'h5A, 1'b1, W);
    cfg_valid = 1'b0;
    wait_done(4);
    check("long_run_len", last_run, 301 * 8);
    check("long_fw_cleared", frame_words, 8'd0);

    repeat (5) begin @(posedge clk); #1; end
    check("final_bits_drained", exp_bits.size(), 0);
    check("final_done_drained", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
